// File: rtl/tl45_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter: per-cycle ownership with round-robin ties,
// combinational pass-through while granted, and a watchdog that aborts hung cycles.
module tl45_wb_arbiter #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_reset_n,

    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    input  logic [3:0]    i_m0_sel,
    output logic          o_m0_ack,
    output logic          o_m0_stall,
    output logic          o_m0_err,
    output logic [DW-1:0] o_m0_data,

    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    input  logic [3:0]    i_m1_sel,
    output logic          o_m1_ack,
    output logic          o_m1_stall,
    output logic          o_m1_err,
    output logic [DW-1:0] o_m1_data,

    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    output logic [3:0]    o_wb_sel,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data,

    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT0,
        S_GRANT1,
        S_ABORT
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic granted, owner, own_cyc, own_stb, other_cyc, last_cyc, wd_hit;

    always_comb begin
        granted   = (state_q == S_GRANT0) || (state_q == S_GRANT1);
        owner     = (state_q == S_GRANT1);
        own_cyc   = owner ? i_m1_cyc : i_m0_cyc;
        own_stb   = owner ? i_m1_stb : i_m0_stb;
        other_cyc = owner ? i_m0_cyc : i_m1_cyc;
        // ABORT keeps no owner of its own; last was set to the owner on entry
        last_cyc  = last_q ? i_m1_cyc : i_m0_cyc;
        wd_hit    = granted && own_cyc && (wd_q == WDW'(TIMEOUT)) && !i_wb_ack && !i_wb_err;
    end

    always_comb begin
        o_wb_cyc   = granted && own_cyc && !wd_hit;
        o_wb_stb   = o_wb_cyc && own_stb;
        o_wb_we    = 1'b0;
        o_wb_addr  = '0;
        o_wb_data  = '0;
        o_wb_sel   = '0;
        if (granted) begin
            o_wb_we   = owner ? i_m1_we   : i_m0_we;
            o_wb_addr = owner ? i_m1_addr : i_m0_addr;
            o_wb_data = owner ? i_m1_data : i_m0_data;
            o_wb_sel  = owner ? i_m1_sel  : i_m0_sel;
        end

        o_m0_stall = 1'b1;
        o_m0_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m1_stall = 1'b1;
        o_m1_ack   = 1'b0;
        o_m1_err   = 1'b0;
        if (state_q == S_GRANT0) begin
            o_m0_stall = i_wb_stall;
            o_m0_ack   = wd_hit || (i_wb_ack && i_m0_cyc);
            o_m0_err   = wd_hit || (i_wb_err && i_m0_cyc);
        end
        if (state_q == S_GRANT1) begin
            o_m1_stall = i_wb_stall;
            o_m1_ack   = wd_hit || (i_wb_ack && i_m1_cyc);
            o_m1_err   = wd_hit || (i_wb_err && i_m1_cyc);
        end

        o_m0_data = i_wb_data;
        o_m1_data = i_wb_data;
        o_grant   = {state_q == S_GRANT1, state_q == S_GRANT0};
        o_timeout = wd_hit;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) state_d = last_q ? S_GRANT0 : S_GRANT1;
                else if (i_m0_cyc)        state_d = S_GRANT0;
                else if (i_m1_cyc)        state_d = S_GRANT1;
            end
            S_GRANT0, S_GRANT1: begin
                if (!own_cyc) begin
                    last_d  = owner;
                    state_d = !other_cyc ? S_IDLE : (owner ? S_GRANT0 : S_GRANT1);
                end else if (wd_hit) begin
                    last_d  = owner;
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                if (!last_cyc) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (!granted || (state_d != state_q) || i_wb_ack || i_wb_err || (o_wb_stb && !i_wb_stall))
            wd_d = '0;
        else
            wd_d = wd_q + WDW'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

endmodule
